// File: rtl/load_store_unit_if.sv
// Execute/writeback handshake and data-memory bus of the load/store unit.
// slave is the unit side; master is the surrounding pipeline and memory.
interface load_store_unit_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 12,
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [DATA_W-1:0] req_base;
  logic [OFF_W-1:0]  req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_write;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_base, req_offset, req_wdata, req_rd,
           rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_write, rsp_err,
           mem_address, mem_wdata, mem_re, mem_we
  );

  modport master (
    output req_valid, req_write, req_base, req_offset, req_wdata, req_rd,
           rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_write, rsp_err,
           mem_address, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: effective-address calc, alignment/range check, one
// access to a synchronous-read data memory, tagged response with backpressure.
module load_store_unit #(
  parameter int DATA_W    = 32,
  parameter int OFF_W     = 12,
  parameter int ADDR_W    = 6,
  parameter int MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] ea;
  logic [1:0]        err_c;

  // Offset is sign-extended to the full width; the add wraps naturally.
  assign ea = bus.req_base + DATA_W'($signed(bus.req_offset));

  always_comb begin
    err_c = 2'b00;
    if (ea[1:0] != 2'b00)
      err_c = 2'b01;
    else if (ea[DATA_W-1:2] >= (DATA_W-2)'(MEM_WORDS))
      err_c = 2'b10;
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    write_d = write_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        rd_d    = bus.req_rd;
        write_d = bus.req_write;
        wdata_d = bus.req_write ? bus.req_wdata : '0;
        // Faulting requests never reach the memory, so keep the bus address clean.
        addr_d  = (err_c == 2'b00) ? ea[ADDR_W+1:2] : '0;
        err_d   = err_c;
        rdata_d = '0;
        state_d = (err_c != 2'b00) ? RESP : ISSUE;
      end
      ISSUE: state_d = write_q ? RESP : WAIT;
      WAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Enables decode straight from state, so async reset kills them at once.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.mem_we      = (state_q == ISSUE) &&  write_q;
  assign bus.mem_re      = (state_q == ISSUE) && !write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = rdata_q;
  assign bus.rsp_rd      = rd_q;
  assign bus.rsp_write   = write_q;
  assign bus.rsp_err     = err_q;
endmodule
